// File: rtl/vga_overlay_ctrl_if.sv
// Configuration request port of vga_overlay_ctrl: valid/ready handshake carrying a 3-bit mode.
// The requester uses the master modport; the overlay controller uses the slave modport.
interface vga_overlay_ctrl_if;
    logic       cfg_valid_in;
    logic [2:0] cfg_mode_in;
    logic       cfg_ready_out;

    modport master (
        output cfg_valid_in,
        output cfg_mode_in,
        input  cfg_ready_out
    );

    modport slave (
        input  cfg_valid_in,
        input  cfg_mode_in,
        output cfg_ready_out
    );
endinterface

// File: rtl/vga_overlay_ctrl.sv
// Frame-synchronous overlay mode controller for the VGA pixel mux.
// A debounced push-button steps the pending mode and a valid/ready port loads it directly.
// The pending mode becomes active only on a new_frame_in pulse, so overlays never change
// mid-frame.
// Optional feature macro: OVERLAY_BLINK_EN (crosshair blinks every BLINK_FRAMES frames).
module vga_overlay_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 650000,
    parameter int unsigned BLINK_FRAMES    = 30
) (
    input  logic              clk_in,
    input  logic              rst_in_n,
    input  logic              btn_in,
    input  logic              new_frame_in,
    vga_overlay_ctrl_if.slave cfg_io,
    output logic [2:0]        mode_out,
    output logic              pending_out,
    output logic              mask_on_out,
    output logic              blue_on_out,
    output logic              crosshair_on_out
);
    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [0:0] {StIdle, StArmed} state_e;

    logic           btn_meta_q, btn_sync_q;
    logic           db_level_q;
    logic [DbW-1:0] db_cnt_q;
    state_e         state_q;
    logic [2:0]     pending_q, active_q;
    logic           defer_q;  // press that coincided with a commit, applied one cycle later

    logic           db_done, press, xfer, press_eff;
    logic [2:0]     pending_inc;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
        end else begin
            btn_meta_q <= btn_in;
            btn_sync_q <= btn_meta_q;
        end
    end

    // Level flips on the last cycle of a full stable run; a rising flip is a press.
    assign db_done = (btn_sync_q != db_level_q) && (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1));
    assign press   = db_done && btn_sync_q;

    // Debounce counter: any return to the current level restarts the run.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
        end else if (btn_sync_q == db_level_q) begin
            db_cnt_q   <= '0;
        end else if (db_done) begin
            db_level_q <= btn_sync_q;
            db_cnt_q   <= '0;
        end else begin
            db_cnt_q   <= db_cnt_q + DbW'(1);
        end
    end

    assign cfg_io.cfg_ready_out = (state_q == StIdle);
    assign xfer                 = cfg_io.cfg_valid_in && cfg_io.cfg_ready_out;
    assign press_eff            = press || defer_q;
    assign pending_inc          = pending_q + 3'd1;

    // Mode FSM: IDLE holds pending == active, ARMED waits for the frame boundary to commit.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q   <= StIdle;
            pending_q <= 3'd0;
            active_q  <= 3'd0;
            defer_q   <= 1'b0;
        end else begin
            defer_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // Config wins over a simultaneous press; the press is dropped.
                    if (xfer) begin
                        pending_q <= cfg_io.cfg_mode_in;
                        if (cfg_io.cfg_mode_in != active_q) state_q <= StArmed;
                    end else if (press_eff) begin
                        // pending == active here, so +1 always differs.
                        pending_q <= pending_inc;
                        state_q   <= StArmed;
                    end
                end
                StArmed: begin
                    if (new_frame_in) begin
                        active_q <= pending_q;
                        state_q  <= StIdle;
                        defer_q  <= press;
                    end else if (press) begin
                        pending_q <= pending_inc;
                        if (pending_inc == active_q) state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mode_out    = active_q;
    assign mask_on_out = active_q[0];
    assign blue_on_out = active_q[1];
    assign pending_out = (state_q == StArmed);

`ifdef OVERLAY_BLINK_EN
    localparam int unsigned BlW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BlW-1:0] blink_cnt_q;
    logic           blink_phase_q;
    logic           xh_enable;

    // Crosshair being switched on by this frame's commit restarts the blink cycle.
    assign xh_enable = (state_q == StArmed) && new_frame_in && !active_q[2] && pending_q[2];

    // Frame counter toggles the blink phase every BLINK_FRAMES frames.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else if (xh_enable) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else if (new_frame_in) begin
            if (blink_cnt_q == BlW'(BLINK_FRAMES - 1)) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q   <= blink_cnt_q + BlW'(1);
            end
        end
    end

    assign crosshair_on_out = active_q[2] & blink_phase_q;
`else
    logic unused_blink;
    assign unused_blink     = ^BLINK_FRAMES;
    assign crosshair_on_out = active_q[2];
`endif
endmodule

// File: tb/tb_vga_overlay_ctrl.sv
// Randomized self-checking bench for vga_overlay_ctrl against a behavioural model,
// with a few literal checks from the directed scenarios.
module tb_vga_overlay_ctrl;
    localparam int unsigned Deb = 4;
    localparam int unsigned Blk = 2;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       btn       = 1'b0;
    logic       new_frame = 1'b0;
    logic [2:0] mode;
    logic       pend, mask, blue, xh;

    int n_vec = 0;
    int n_bad = 0;

    vga_overlay_ctrl_if cfg_if ();

    vga_overlay_ctrl #(
        .DEBOUNCE_CYCLES(Deb),
        .BLINK_FRAMES   (Blk)
    ) dut (
        .clk_in          (clk),
        .rst_in_n        (rst_n),
        .btn_in          (btn),
        .new_frame_in    (new_frame),
        .cfg_io          (cfg_if),
        .mode_out        (mode),
        .pending_out     (pend),
        .mask_on_out     (mask),
        .blue_on_out     (blue),
        .crosshair_on_out(xh)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit [2:0] m_pending = 3'd0;
    bit [2:0] m_active  = 3'd0;
    bit       m_armed   = 1'b0;
    bit       m_defer   = 1'b0;
    bit       m_meta    = 1'b0;
    bit       m_sync    = 1'b0;
    bit       m_level   = 1'b0;
    int       m_run     = 0;
    int       m_frames  = 0;  // frames since crosshair was last switched on (or reset)

    task automatic model_step();
        bit press;
        bit was_x;
        press = 1'b0;
        if (m_sync != m_level) begin
            m_run++;
            if (m_run == int'(Deb)) begin
                m_level = m_sync;
                m_run   = 0;
                press   = m_sync;
            end
        end else begin
            m_run = 0;
        end
        m_sync = m_meta;
        m_meta = btn;
        if (!m_armed) begin
            if (cfg_if.cfg_valid_in) m_pending = cfg_if.cfg_mode_in;
            else if (press || m_defer) m_pending = m_pending + 3'd1;
            m_defer = 1'b0;
            m_armed = (m_pending != m_active);
            if (new_frame) m_frames++;
        end else if (new_frame) begin
            was_x    = m_active[2];
            m_active = m_pending;
            m_armed  = 1'b0;
            m_defer  = press;
            if (!was_x && m_active[2]) m_frames = 0;
            else m_frames++;
        end else begin
            if (press) m_pending = m_pending + 3'd1;
            m_armed = (m_pending != m_active);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pending = 3'd0; m_active = 3'd0; m_armed = 1'b0; m_defer = 1'b0;
            m_meta = 1'b0; m_sync = 1'b0; m_level = 1'b0; m_run = 0; m_frames = 0;
        end else begin
            model_step();
        end
    end

    function automatic bit exp_xh();
`ifdef OVERLAY_BLINK_EN
        return m_active[2] && (((m_frames / int'(Blk)) % 2) == 0);
`else
        return m_active[2];
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        chk("mode_out", int'(mode), int'(m_active));
        chk("mask_on_out", int'(mask), int'(m_active[0]));
        chk("blue_on_out", int'(blue), int'(m_active[1]));
        chk("crosshair_on_out", int'(xh), int'(exp_xh()));
        chk("pending_out", int'(pend), int'(m_armed));
        chk("cfg_ready_out", int'(cfg_if.cfg_ready_out), int'(!m_armed));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_pulse();
        new_frame = 1'b1;
        step(1);
        new_frame = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit       xfer_next;
        int       btn_hold;
        bit [4:0] blink_tbl;
        cfg_if.cfg_valid_in = 1'b0;
        cfg_if.cfg_mode_in  = 3'd0;
        #1 rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;

        // Idle after reset.
        step(20);
        chk("idle mode", int'(mode), 0);
        chk("idle ready", int'(cfg_if.cfg_ready_out), 1);
        chk("idle pending", int'(pend), 0);

        // Clean press: press lands on the 6th edge after the button is driven.
        btn = 1'b1;
        step(5);
        chk("press latency early", int'(pend), 0);
        step(1);
        chk("press latency", int'(pend), 1);
        chk("press no commit", int'(mode), 0);
        step(4);
        btn = 1'b0;
        step(8);
        frame_pulse();
        chk("press commit mode", int'(mode), 1);
        chk("press commit mask", int'(mask), 1);
        chk("press commit pend", int'(pend), 0);

        // Bounce 1-0-1-0 then stable high: one increment.
        for (int i = 0; i < 4; i++) begin
            btn = ~btn;
            step(2);
        end
        btn = 1'b1;
        step(12);
        btn = 1'b0;
        step(8);
        frame_pulse();
        chk("bounce single inc", int'(mode), 2);

        // Config 110 accepted, second request held off until the frame.
        cfg_if.cfg_valid_in = 1'b1;
        cfg_if.cfg_mode_in  = 3'b110;
        step(1);
        chk("cfg accept pend", int'(pend), 1);
        chk("cfg ready drop", int'(cfg_if.cfg_ready_out), 0);
        cfg_if.cfg_mode_in = 3'b001;
        step(3);
        chk("cfg held off", int'(cfg_if.cfg_ready_out), 0);
        chk("cfg held mode", int'(mode), 2);
        frame_pulse();
        chk("cfg commit mode", int'(mode), 6);
        chk("cfg commit blue", int'(blue), 1);
        chk("cfg commit xh", int'(xh), 1);
        step(1);
        chk("cfg second accept", int'(pend), 1);
        cfg_if.cfg_valid_in = 1'b0;
        frame_pulse();
        chk("cfg second commit", int'(mode), 1);

        // Eight presses wrap pending back to active.
        for (int i = 0; i < 8; i++) begin
            btn = 1'b1;
            step(7);
            btn = 1'b0;
            step(7);
        end
        chk("wrap idle", int'(pend), 0);
        frame_pulse();
        chk("wrap no change", int'(mode), 1);

        // Config transfer on the same edge as a press: config wins.
        btn = 1'b1;
        step(5);
        cfg_if.cfg_valid_in = 1'b1;
        cfg_if.cfg_mode_in  = 3'b101;
        step(1);
        cfg_if.cfg_valid_in = 1'b0;
        chk("collide pend", int'(pend), 1);
        step(5);
        btn = 1'b0;
        step(8);
        frame_pulse();
        chk("collide cfg wins", int'(mode), 5);

        // Asynchronous reset while ARMED.
        cfg_if.cfg_valid_in = 1'b1;
        cfg_if.cfg_mode_in  = 3'b011;
        step(1);
        cfg_if.cfg_valid_in = 1'b0;
        chk("pre-reset armed", int'(pend), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset mode", int'(mode), 0);
        chk("reset pend", int'(pend), 0);
        chk("reset ready", int'(cfg_if.cfg_ready_out), 1);
        chk("reset overlays", int'({mask, blue, xh}), 0);
        step(1);
        #2 rst_n = 1'b1;
        step(2);

`ifdef OVERLAY_BLINK_EN
        // Crosshair phase after k frames following enable: 1,0,0,1,1.
        blink_tbl = 5'b11001;
        cfg_if.cfg_valid_in = 1'b1;
        cfg_if.cfg_mode_in  = 3'b100;
        step(1);
        cfg_if.cfg_valid_in = 1'b0;
        frame_pulse();
        chk("blink start", int'(xh), 1);
        for (int k = 0; k < 5; k++) begin
            frame_pulse();
            step(1);
            chk("blink phase", int'(xh), int'(blink_tbl[k]));
        end
`else
        blink_tbl = 5'b0;
`endif

        // Randomized traffic.
        xfer_next = 1'b0;
        btn_hold  = 0;
        for (int i = 0; i < 4000; i++) begin
            if (btn_hold == 0) begin
                btn      = 1'($urandom);
                btn_hold = int'($urandom_range(10, 1));
            end else begin
                btn_hold--;
            end
            new_frame = ($urandom_range(15, 0) == 0);
            if (cfg_if.cfg_valid_in && xfer_next) begin
                cfg_if.cfg_valid_in = 1'b0;
            end else if (!cfg_if.cfg_valid_in && $urandom_range(9, 0) == 0) begin
                cfg_if.cfg_valid_in = 1'b1;
                cfg_if.cfg_mode_in  = 3'($urandom);
            end
            xfer_next = cfg_if.cfg_valid_in && cfg_if.cfg_ready_out;
            step(1);
        end
        new_frame = 1'b0;
        cfg_if.cfg_valid_in = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
